// File: rtl/fifo_rr_arbiter_pkg.sv
// fifo_rr_arbiter shared definitions.
// State encoding, port counts and small one-hot helpers.
package fifo_rr_arbiter_pkg;

   localparam int NUM_IN       = 4;
   localparam int NUM_OUT      = 2;
   localparam int DW_DEF       = 6;
   localparam int DEST_BIT_DEF = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      PAUSE  = 2'd2
   } arb_state_e;

   // index of the set bit of a one-hot nibble
   function automatic logic [1:0] oh2idx(input logic [3:0] oh);
      return {oh[3] | oh[2], oh[3] | oh[1]};
   endfunction

   // more than one bit set
   function automatic logic multi_hot(input logic [3:0] v);
      return (v & (v - 4'd1)) != 4'd0;
   endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotating priority encoder.
// Searches ptr, ptr+1, ... mod 4 and returns the first eligible input one-hot.
module rr_pick
   import fifo_rr_arbiter_pkg::*;
(
   input  logic [NUM_IN-1:0] eligible,
   input  logic [1:0]        ptr,
   output logic [NUM_IN-1:0] grant,
   output logic              any
);

   logic       found;
   logic [1:0] idx;

   // walk the inputs starting at ptr, keep the first hit
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = ptr;
      for (int k = 0; k < NUM_IN; k++) begin
         idx = ptr + 2'(k);
         if (!found && eligible[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   assign any = |eligible;

endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin pop of four input FIFOs, routed to two outputs.
// Optional per-input grant counters with FIFO_RR_ARBITER_STATS_EN.
module fifo_rr_arbiter
   import fifo_rr_arbiter_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int DEST_BIT = DEST_BIT_DEF
)(
   input  logic          clk,
   input  logic          reset_L,
   input  logic [3:0]    fifo_empty_in,
   input  logic [3:0]    valid_in,
   input  logic [DW-1:0] data_in0,
   input  logic [DW-1:0] data_in1,
   input  logic [DW-1:0] data_in2,
   input  logic [DW-1:0] data_in3,
   input  logic [5:0]    error_in,
   input  logic [1:0]    almost_full_in,
   input  logic [1:0]    almost_empty_in,
`ifdef FIFO_RR_ARBITER_STATS_EN
   output logic [31:0]   grant_cnt,
`endif
   output logic [3:0]    pop_out,
   output logic          push_out0,
   output logic          push_out1,
   output logic [DW-1:0] data_out,
   output logic          paused,
   output logic          error_out
);

   arb_state_e    state_q, state_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [1:0]    mask_q, mask_d;
   logic [3:0]    pop_q, pop_d;
   logic [3:0]    pop_prev_q, pop_prev_d;
   logic          push0_q, push0_d;
   logic          push1_q, push1_d;
   logic [DW-1:0] data_q, data_d;
   logic          paused_q, paused_d;
   logic          err_q, err_d;

   logic [3:0]    elig;
   logic [3:0]    grant;
   logic          any_elig;
   logic          do_grant;
   logic [3:0]    take;
   logic [DW-1:0] word;
   logic          push_any;

   // an input popped last cycle still shows non-empty; mask it once
   assign elig = ~fifo_empty_in & ~pop_q;

   rr_pick u_pick (
      .eligible (elig),
      .ptr      (ptr_q),
      .grant    (grant),
      .any      (any_elig)
   );

   // next state, pause mask and pause flag
   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      if (almost_full_in != 2'b00) begin
         state_d = PAUSE;
         mask_d  = mask_q | almost_full_in;
      end else begin
         unique case (state_q)
            PAUSE: begin
               if ((almost_empty_in & mask_q) == mask_q) begin
                  mask_d  = 2'b00;
                  state_d = any_elig ? ACTIVE : IDLE;
               end
            end
            default: state_d = any_elig ? ACTIVE : IDLE;
         endcase
      end
      paused_d = (state_d == PAUSE);
   end

   // issue at most one pop and advance the pointer past the winner
   always_comb begin
      do_grant = (state_d == ACTIVE);
      pop_d    = do_grant ? grant : 4'b0000;
      ptr_d    = do_grant ? oh2idx(grant) + 2'd1 : ptr_q;
      pop_prev_d = pop_q;
   end

   // accept the word answering last cycle's pop and route it
   always_comb begin
      take = valid_in & pop_prev_q;
      word = '0;
      unique case (1'b1)
         take[0]: word = data_in0;
         take[1]: word = data_in1;
         take[2]: word = data_in2;
         take[3]: word = data_in3;
         default: word = '0;
      endcase
      push_any = |take;
      push0_d  = push_any & ~word[DEST_BIT];
      push1_d  = push_any &  word[DEST_BIT];
      data_d   = push_any ? word : data_q;
   end

   // sticky error from FIFO flags and protocol violations
   always_comb begin
      err_d = err_q
            | (|error_in)
            | (|(valid_in & ~pop_prev_q))
            | multi_hot(valid_in);
   end

   // state and output registers
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q    <= IDLE;
         ptr_q      <= 2'd0;
         mask_q     <= 2'b00;
         pop_q      <= 4'b0000;
         pop_prev_q <= 4'b0000;
         push0_q    <= 1'b0;
         push1_q    <= 1'b0;
         data_q     <= '0;
         paused_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         mask_q     <= mask_d;
         pop_q      <= pop_d;
         pop_prev_q <= pop_prev_d;
         push0_q    <= push0_d;
         push1_q    <= push1_d;
         data_q     <= data_d;
         paused_q   <= paused_d;
         err_q      <= err_d;
      end
   end

   assign pop_out   = pop_q;
   assign push_out0 = push0_q;
   assign push_out1 = push1_q;
   assign data_out  = data_q;
   assign paused    = paused_q;
   assign error_out = err_q;

`ifdef FIFO_RR_ARBITER_STATS_EN
   logic [3:0][7:0] cnt_q, cnt_d;

   // saturating grant counters, one per input
   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < NUM_IN; i++) begin
         if (do_grant && grant[i] && cnt_q[i] != 8'hFF)
            cnt_d[i] = cnt_q[i] + 8'd1;
      end
   end

   // counter registers
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: directed scoreboard bench for fifo_rr_arbiter.
// Behavioural input FIFOs answer pops; a monitor checks pops and pushes.
module tb_fifo_rr_arbiter;

   logic       clk = 1'b0;
   logic       reset_L;
   logic [3:0] mdl_empty;
   logic [3:0] mdl_valid;
   logic [3:0] inj_valid;
   logic [3:0] valid_in;
   logic [5:0] mdl_data [4];
   logic [5:0] error_in;
   logic [1:0] almost_full_in;
   logic [1:0] almost_empty_in;
   logic [3:0] pop_out;
   logic       push_out0;
   logic       push_out1;
   logic [5:0] data_out;
   logic       paused;
   logic       error_out;
`ifdef FIFO_RR_ARBITER_STATS_EN
   logic [31:0] grant_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic [5:0] q0[$];
   logic [5:0] q1[$];
   logic [5:0] q2[$];
   logic [5:0] q3[$];
   logic [3:0] exp_pop[$];
   logic [7:0] exp_push[$];
   int         infl[$];
   int         pop_cyc[$];

   assign valid_in = mdl_valid | inj_valid;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fifo_rr_arbiter dut (
      .clk             (clk),
      .reset_L         (reset_L),
      .fifo_empty_in   (mdl_empty),
      .valid_in        (valid_in),
      .data_in0        (mdl_data[0]),
      .data_in1        (mdl_data[1]),
      .data_in2        (mdl_data[2]),
      .data_in3        (mdl_data[3]),
      .error_in        (error_in),
      .almost_full_in  (almost_full_in),
      .almost_empty_in (almost_empty_in),
`ifdef FIFO_RR_ARBITER_STATS_EN
      .grant_cnt       (grant_cnt),
`endif
      .pop_out         (pop_out),
      .push_out0       (push_out0),
      .push_out1       (push_out1),
      .data_out        (data_out),
      .paused          (paused),
      .error_out       (error_out)
   );

   function automatic logic [5:0] take_word(input int i);
      logic [5:0] w;
      w = 6'd0;
      case (i)
         0: if (q0.size() != 0) w = q0.pop_front();
         1: if (q1.size() != 0) w = q1.pop_front();
         2: if (q2.size() != 0) w = q2.pop_front();
         default: if (q3.size() != 0) w = q3.pop_front();
      endcase
      return w;
   endfunction

   task automatic load(input int i, input logic [5:0] w);
      case (i)
         0: q0.push_back(w);
         1: q1.push_back(w);
         2: q2.push_back(w);
         default: q3.push_back(w);
      endcase
   endtask

   // input FIFO model: word appears the cycle after its pop, empty lags by one
   always @(posedge clk) begin : mdl
      logic [3:0] p;
      p = pop_out;
      #1;
      if (!reset_L) begin
         q0.delete(); q1.delete(); q2.delete(); q3.delete();
         mdl_valid = 4'b0000;
      end else begin
         mdl_valid = 4'b0000;
         for (int i = 0; i < 4; i++) begin
            if (p[i]) begin
               mdl_valid[i] = 1'b1;
               mdl_data[i]  = take_word(i);
            end
         end
      end
      mdl_empty = {q3.size() == 0, q2.size() == 0,
                   q1.size() == 0, q0.size() == 0};
   end

   // monitor: compare every pop and push against the scoreboard
   always @(negedge clk) begin
      if (reset_L) begin
         if (pop_out != 4'b0000) begin
            n_chk++;
            if (exp_pop.size() == 0) begin
               n_fail++;
               $display("FAIL pop_unexpected: got %b want none", pop_out);
            end else begin
               logic [3:0] e;
               e = exp_pop.pop_front();
               if (pop_out !== e) begin
                  n_fail++;
                  $display("FAIL pop_order: got %b want %b", pop_out, e);
               end
            end
            infl.push_back(cyc);
            pop_cyc.push_back(cyc);
         end
         if (push_out0 || push_out1) begin
            logic [7:0] o;
            o = {push_out1, push_out0, data_out};
            n_chk++;
            if (exp_push.size() == 0) begin
               n_fail++;
               $display("FAIL push_unexpected: got %b want none", o);
            end else begin
               logic [7:0] e;
               e = exp_push.pop_front();
               if (o !== e) begin
                  n_fail++;
                  $display("FAIL push_word: got %b want %b", o, e);
               end
            end
            n_chk++;
            if (infl.size() == 0) begin
               n_fail++;
               $display("FAIL push_latency: got push with no pop want pop 2 cycles earlier");
            end else begin
               int d;
               d = cyc - infl.pop_front();
               if (d != 2) begin
                  n_fail++;
                  $display("FAIL push_latency: got %0d want 2", d);
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic drain();
      int b;
      b = 0;
      while ((exp_pop.size() != 0 || exp_push.size() != 0) && b < 60) begin
         @(negedge clk);
         b++;
      end
      n_chk++;
      if (exp_pop.size() != 0 || exp_push.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d pops %0d pushes pending want 0",
                  exp_pop.size(), exp_push.size());
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_pop();
      bit ok;
      ok = 1'b0;
      for (int b = 0; b < 30 && !ok; b++) begin
         @(negedge clk);
         if (pop_out != 4'b0000) ok = 1'b1;
      end
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL wait_pop_timeout: got no pop want a pop");
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_pop"},   32'(pop_out),   32'd0);
      chk({tag, "_push0"}, 32'(push_out0), 32'd0);
      chk({tag, "_push1"}, 32'(push_out1), 32'd0);
      chk({tag, "_data"},  32'(data_out),  32'd0);
      chk({tag, "_paused"}, 32'(paused),   32'd0);
      chk({tag, "_error"}, 32'(error_out), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_L         = 1'b0;
      inj_valid       = 4'b0000;
      mdl_valid       = 4'b0000;
      mdl_empty       = 4'b1111;
      error_in        = 6'd0;
      almost_full_in  = 2'b00;
      almost_empty_in = 2'b00;
      for (int i = 0; i < 4; i++) mdl_data[i] = 6'd0;

      repeat (2) @(negedge clk);
      chk_idle_outputs("reset");
      reset_L = 1'b1;
      repeat (2) @(negedge clk);

      // round robin over all four, input 0 holds two words
      pop_cyc.delete();
      load(0, 6'b000001); load(0, 6'b100010);
      load(1, 6'b100101); load(2, 6'b000110); load(3, 6'b000011);
      exp_pop.push_back(4'b0001); exp_pop.push_back(4'b0010);
      exp_pop.push_back(4'b0100); exp_pop.push_back(4'b1000);
      exp_pop.push_back(4'b0001);
      exp_push.push_back(8'b01_000001); exp_push.push_back(8'b10_100101);
      exp_push.push_back(8'b01_000110); exp_push.push_back(8'b01_000011);
      exp_push.push_back(8'b10_100010);
      drain();
      n_chk++;
      if (pop_cyc.size() != 5) begin
         n_fail++;
         $display("FAIL rr_pop_count: got %0d want 5", pop_cyc.size());
      end else if (pop_cyc[4] - pop_cyc[0] != 4) begin
         n_fail++;
         $display("FAIL rr_back_to_back: got span %0d want 4",
                  pop_cyc[4] - pop_cyc[0]);
      end

      // single word in input 2: exactly one pop
      load(2, 6'b000111);
      exp_pop.push_back(4'b0100);
      exp_push.push_back(8'b01_000111);
      drain();
      chk("single_word_error", 32'(error_out), 32'd0);

      // pause with two words in flight; ptr now points at input 3
      load(0, 6'b000100); load(0, 6'b110000);
      load(1, 6'b101010); load(1, 6'b001001);
      load(2, 6'b011111); load(2, 6'b111110);
      load(3, 6'b100001); load(3, 6'b010101);
      exp_pop.push_back(4'b1000); exp_pop.push_back(4'b0001);
      exp_pop.push_back(4'b0010); exp_pop.push_back(4'b0100);
      exp_pop.push_back(4'b1000); exp_pop.push_back(4'b0001);
      exp_pop.push_back(4'b0010); exp_pop.push_back(4'b0100);
      exp_push.push_back(8'b10_100001); exp_push.push_back(8'b01_000100);
      exp_push.push_back(8'b10_101010); exp_push.push_back(8'b01_011111);
      exp_push.push_back(8'b01_010101); exp_push.push_back(8'b10_110000);
      exp_push.push_back(8'b01_001001); exp_push.push_back(8'b10_111110);
      wait_pop();
      @(negedge clk);
      almost_full_in = 2'b01;
      @(negedge clk);
      chk("pause_pop", 32'(pop_out), 32'd0);
      chk("pause_flag", 32'(paused), 32'd1);
      repeat (3) @(negedge clk);
      chk("pause_inflight_pushed", 32'(exp_push.size()), 32'd6);
      chk("pause_pops_left", 32'(exp_pop.size()), 32'd6);
      almost_full_in = 2'b00;
      repeat (3) @(negedge clk);
      chk("pause_hold_flag", 32'(paused), 32'd1);
      chk("pause_hold_pops", 32'(exp_pop.size()), 32'd6);
      almost_empty_in = 2'b01;
      drain();
      chk("resume_flag", 32'(paused), 32'd0);
      almost_empty_in = 2'b00;

      // error_in pulse is sticky
      chk("pre_error", 32'(error_out), 32'd0);
      @(negedge clk);
      error_in = 6'b001000;
      @(negedge clk);
      error_in = 6'd0;
      chk("error_set", 32'(error_out), 32'd1);
      repeat (5) @(negedge clk);
      chk("error_sticky", 32'(error_out), 32'd1);

      // reset mid-traffic; ptr points at input 3 before reset
      load(0, 6'b000010); load(1, 6'b100011);
      load(2, 6'b000100); load(3, 6'b100110);
      exp_pop.push_back(4'b1000); exp_pop.push_back(4'b0001);
      exp_pop.push_back(4'b0010); exp_pop.push_back(4'b0100);
      wait_pop();
      @(negedge clk);
      #2;
      reset_L = 1'b0;
      #1;
      chk_idle_outputs("midreset");
      exp_pop.delete(); exp_push.delete(); infl.delete();
      repeat (2) @(negedge clk);
      chk_idle_outputs("inreset");
      reset_L = 1'b1;
      @(negedge clk);
      load(0, 6'b101000); load(1, 6'b000101);
      load(2, 6'b111000); load(3, 6'b001110);
      exp_pop.push_back(4'b0001); exp_pop.push_back(4'b0010);
      exp_pop.push_back(4'b0100); exp_pop.push_back(4'b1000);
      exp_push.push_back(8'b10_101000); exp_push.push_back(8'b01_000101);
      exp_push.push_back(8'b10_111000); exp_push.push_back(8'b01_001110);
      drain();

      // spurious valid with no pop
      chk("pre_spurious_error", 32'(error_out), 32'd0);
      @(negedge clk);
      inj_valid = 4'b0001;
      @(negedge clk);
      inj_valid = 4'b0000;
      chk("error_spurious_valid", 32'(error_out), 32'd1);
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
- Round-robin arbiter that sits directly downstream of four input fifo_c instances.
- Pops the input FIFOs in turn and routes each popped word to one of two downstream fifo_c instances, selected by the word's destination bit.
- Applies almost_full/almost_empty hysteresis flow control from the downstream FIFOs.
- Collects FIFO error flags into a sticky error for the top-level state machine.

Parameters:
- DW, 6, data width; fixed at 6 in this design.
- DEST_BIT, 5, bit of the data word that selects the output: 0 routes to out0, 1 routes to out1.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset_L  in  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
- fifo_empty_in  in  4  fifo_empty_c of input FIFOs 0..3.
- valid_in  in  4  valid_out_c of input FIFOs 0..3.
- data_in0..data_in3  in  DW each  data_out_c of input FIFOs 0..3.
- error_in  in  6  error_c of input FIFOs [3:0] and output FIFOs [5:4].
- almost_full_in  in  2  almost_full_c of output FIFOs 0,1.
- almost_empty_in  in  2  almost_empty_c of output FIFOs 0,1.
- pop_out  out  4  one-hot registered pop to input FIFOs.
- push_out0, push_out1  out  1 each  registered push to output FIFOs.
- data_out  out  DW  registered data; shared by both outputs.
- paused  out  1  1 while in PAUSE.
- error_out  out  1  sticky error.

Behaviour:
- Reset (reset_L=0, asynchronous): pop_out=0, both push_out=0, data_out=0, paused=0, error_out=0, round-robin pointer ptr=0, state IDLE, mask cleared.
- State machine:
  - IDLE: no eligible input.
  - ACTIVE: granting.
  - PAUSE: no grants issued.
  - IDLE<->ACTIVE: recomputed every cycle from eligibility.
  - Any state -> PAUSE: when almost_full_in!=0. Latch pause_mask=almost_full_in on entry; OR in new bits while in PAUSE.
  - PAUSE exit: when almost_full_in==0 and (almost_empty_in & pause_mask)==pause_mask. Then clear pause_mask and go to IDLE/ACTIVE.
- Eligibility:
  - Input i is eligible when fifo_empty_in[i]==0 and pop_out[i] was not asserted in the previous cycle.
  - The mask exists because the empty flag lags by one cycle, so a FIFO holding one word is never popped twice.
- Grant:
  - In ACTIVE, pick the first eligible i searching ptr, ptr+1, ... mod 4.
  - Next cycle pop_out has bit i set for exactly one cycle, and ptr becomes (i+1) mod 4.
  - At most one grant per cycle; back-to-back grants to different inputs are allowed.
- Latency:
  - Grant decision at edge t gives pop_out high during cycle t.
  - The FIFO presents valid_in/data during t+1.
  - Arbiter registers them, so push_outX and data_out are high during t+2.
  - Sustained throughput is one word per cycle; at most 2 words in flight.
- Routing:
  - data[DEST_BIT]=0 asserts push_out0; 1 asserts push_out1. Never both.
  - data_out is passed through unmodified.
- Pause:
  - Stops new grants from the cycle after almost_full_in rises.
  - Words already in flight (≤2) are still pushed.
  - Downstream almost_full threshold must leave ≥2 free slots.
- Errors: error_out sets and holds until reset on any of:
  - any error_in bit high;
  - valid_in with no pop_out on that input in the previous cycle;
  - more than one valid_in bit in the same cycle.
- Reset mid-operation: in-flight words are dropped, with no push after reset_L falls.

Optional Feature:
- Macro: FIFO_RR_ARBITER_STATS_EN.
- When defined: adds output grant_cnt, 32 bits, four 8-bit saturating counters of grants per input ([7:0]=input 0). Counters reset to 0 and hold at 255.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, ACTIVE=2'd1, PAUSE=2'd2;
  - NUM_IN=4, NUM_OUT=2;
  - DEST_BIT default.
- One natural sub-module: rr_pick, a combinational rotating priority encoder. Inputs: eligible[3:0], ptr[1:0]. Outputs: grant one-hot[3:0], any.

Test Plan:
- reset_L=0 mid-traffic -> all outputs 0 immediately. After release, the first grant goes to input 0 when all inputs are non-empty.
- All four inputs non-empty, no pause -> pop_out 0001,0010,0100,1000,0001 on consecutive cycles. A push follows each pop two cycles later.
- Only input 2 non-empty, holding 1 word -> pop_out=0100 for one cycle and not the next. No error_out.
- Input 1 returns 6'b100101 -> push_out1=1 with data_out=6'b100101. Input 3 returns 6'b000011 -> push_out0=1. The other push stays 0.
- almost_full_in=01 during traffic -> pop_out=0 from the next cycle and paused=1; the 2 in-flight words are still pushed. almost_full_in=00 with almost_empty_in=00 -> stays paused. almost_empty_in=01 -> grants resume.
- error_in[3] pulsed one cycle -> error_out=1 and held until reset. A spurious valid_in[0] with no prior pop -> error_out=1.
